// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Indexed {row, col}: row 0 is the top of the keypad, col 0 the left column.
  localparam logic [3:0] KEY_MAP [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} kp_state_t;
  typedef enum logic [1:0] {NONE, ONE, MULTI} scan_class_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Modulo-SCAN_TICKS counter producing a one-cycle tick on the last dwell cycle.
module scan_tick_gen #(
  parameter int SCAN_TICKS = 200_000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_TICKS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobing 4x4 keypad scanner with per-scan debounce and one-shot key reporting.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 200_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic                key_pressed
);

  localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_SCANS);

  function automatic scan_class_t classify(input logic [15:0] snap);
    int n;
    n = $countones(snap);
    if (n == 0) return NONE;
    else if (n == 1) return ONE;
    else return MULTI;
  endfunction

  // Snapshot bit (4*c + r) holds the key at row r, column c.
  function automatic logic [3:0] decode(input logic [15:0] snap);
    logic [3:0] k;
    k = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (snap[c*NUM_ROWS + r]) k = KEY_MAP[r*NUM_COLS + c];
      end
    end
    return k;
  endfunction

  logic [3:0]      row_p0, row_p1;
  logic            tick;
  logic [1:0]      col_idx;
  logic [1:0]      col_next;
  logic [15:0]     snapshot;
  logic [15:0]     snap_next;
  logic            scan_done;
  scan_class_t     scan_class;
  logic [3:0]      scan_code;
  kp_state_t       state;
  logic [3:0]      candidate;
  logic [DB_W-1:0] db_count;
  logic [DB_W-1:0] db_inc;

  scan_tick_gen #(.SCAN_TICKS(SCAN_TICKS)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Stage p0/p1: two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_p0 <= 4'b1111;
      row_p1 <= 4'b1111;
    end else begin
      row_p0 <= row;
      row_p1 <= row_p0;
    end
  end

  assign col_next  = col_idx + 2'd1;
  assign scan_done = tick && (col_idx == 2'd3);

  always_comb begin
    snap_next = snapshot;
    snap_next[{col_idx, 2'b00} +: 4] = ~row_p1;
  end

  assign scan_class = classify(snap_next);
  assign scan_code  = decode(snap_next);
  assign db_inc     = db_count + DB_W'(1);

  // Column strobe and snapshot capture on the last dwell cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_idx  <= 2'd0;
      col      <= 4'b1110;
      snapshot <= '0;
    end else if (tick) begin
      snapshot <= snap_next;
      col_idx  <= col_next;
      col      <= ~(4'b0001 << col_next);
    end
  end

  // Debounce FSM, advanced once per completed scan.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      candidate   <= '0;
      db_count    <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_pressed <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        case (state)
          IDLE: begin
            if (scan_class == ONE) begin
              candidate <= scan_code;
              db_count  <= DB_W'(1);
              if (DEBOUNCE_SCANS == 1) begin
                state       <= HELD;
                key_code    <= scan_code;
                key_valid   <= 1'b1;
                key_pressed <= 1'b1;
              end else begin
                state <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (scan_class == ONE) begin
              if (scan_code == candidate) begin
                db_count <= db_inc;
                if (db_inc == DB_LAST) begin
                  state       <= HELD;
                  key_code    <= candidate;
                  key_valid   <= 1'b1;
                  key_pressed <= 1'b1;
                end
              end else begin
                candidate <= scan_code;
                db_count  <= DB_W'(1);
              end
            end else begin
              state    <= IDLE;
              db_count <= '0;
            end
          end
          HELD: begin
            // Extra keys while held are ignored: no rollover, no auto-repeat.
            if (scan_class == NONE) begin
              db_count <= DB_W'(1);
              if (DEBOUNCE_SCANS == 1) begin
                state       <= IDLE;
                key_pressed <= 1'b0;
              end else begin
                state <= REL_DB;
              end
            end
          end
          REL_DB: begin
            if (scan_class == NONE) begin
              db_count <= db_inc;
              if (db_inc == DB_LAST) begin
                state       <= IDLE;
                key_pressed <= 1'b0;
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model, pulse scoreboard, vector table and corner sequences.
module tb_keypad_scanner;

  localparam int ST   = 4;
  localparam int DB   = 2;
  localparam int SCAN = 4 * ST;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [15:0] k;
    int          press_scans;
    int          rel_scans;
    logic        expect_pulse;
    logic [3:0]  code_after;
  } vec_t;
  vec_t vecs [5];

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
    .clock       (clock),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_pressed (key_pressed)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // keys[r*4+c] pulls row r low while column c is strobed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Return at the negedge just after col wraps 0111 -> 1110 (start of a scan).
  task automatic align();
    logic [3:0] prev;
    prev = col;
    for (int g = 0; g < 64; g++) begin
      @(negedge clock);
      if (prev == 4'b0111 && col == 4'b1110) return;
      prev = col;
    end
    checks++;
    errors++;
    $display("FAIL align: column wrap not seen, col=%b", col);
  endtask

  task automatic expect_pulse(input logic [3:0] code, input int at);
    exp_t e;
    e.code = code;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Pulse monitor: every key_valid must match the head of the scoreboard.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (key_valid) begin
          check("valid_back_to_back", int'(prev_valid), 0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got code %0h at cycle %0d, expected no pulse", key_code, cyc);
          end else begin
            e = sb.pop_front();
            check("pulse_code", key_code, e.code);
            check("pulse_cycle", cyc, e.at);
            check("pressed_with_valid", key_pressed, 1);
          end
        end
        prev_valid = key_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [3:0] exp_col;

    vecs[0] = '{16'h0001, 3, 3, 1'b1, 4'h1};
    vecs[1] = '{16'h8000, 3, 3, 1'b1, 4'hD};
    vecs[2] = '{16'h1000, 2, 3, 1'b1, 4'h0};
    vecs[3] = '{16'h0800, 4, 3, 1'b1, 4'hC};
    vecs[4] = '{16'h0020, 1, 3, 1'b0, 4'hC};

    keys  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Asynchronous reset in the middle of column 1's dwell.
    tick_n(6);
    check("pre_reset_col", col, 4'b1101);
    #2 reset = 1'b1;
    #1;
    check("reset_col", col, 4'b1110);
    check("reset_valid", key_valid, 0);
    check("reset_code", key_code, 0);
    check("reset_pressed", key_pressed, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      check("col_walk", col, exp_col);
      @(negedge clock);
    end

    // Key "6" held for 5 scans, then released.
    align();
    s = cyc;
    keys = 16'h0040;
    expect_pulse(4'h6, s + 2*SCAN);
    tick_n(2*SCAN - 1);
    check("pressed_before_accept", key_pressed, 0);
    tick_n(3*SCAN + 1);
    keys = '0;
    tick_n(2*SCAN - 1);
    check("pressed_before_release", key_pressed, 1);
    tick_n(1);
    check("pressed_after_release", key_pressed, 0);
    check("code_6", key_code, 4'h6);

    for (int v = 0; v < 5; v++) begin
      align();
      s = cyc;
      keys = vecs[v].k;
      if (vecs[v].expect_pulse) expect_pulse(vecs[v].code_after, s + 2*SCAN);
      tick_n(vecs[v].press_scans * SCAN);
      check("vec_pressed", key_pressed, int'(vecs[v].expect_pulse));
      keys = '0;
      tick_n(vecs[v].rel_scans * SCAN);
      check("vec_released", key_pressed, 0);
      check("vec_code", key_code, vecs[v].code_after);
    end

    // Bouncing "9": one scan on, one scan off, four times.
    align();
    repeat (4) begin
      keys = 16'h0400;
      tick_n(SCAN);
      keys = '0;
      tick_n(SCAN);
    end
    check("bounce_code", key_code, 4'hC);
    check("bounce_pressed", key_pressed, 0);

    // Hold "A", add "3", drop "A", then release all.
    align();
    s = cyc;
    keys = 16'h0008;
    expect_pulse(4'hA, s + 2*SCAN);
    tick_n(3*SCAN);
    keys = 16'h000C;
    tick_n(3*SCAN);
    check("a3_pressed", key_pressed, 1);
    keys = 16'h0004;
    tick_n(3*SCAN);
    check("3only_pressed", key_pressed, 1);
    keys = '0;
    tick_n(4*SCAN);
    check("a3_released", key_pressed, 0);
    check("a3_code", key_code, 4'hA);

    // "1" and "D" together, then "D" released.
    align();
    keys = 16'h8001;
    tick_n(3*SCAN);
    check("multi_pressed", key_pressed, 0);
    s = cyc;
    keys = 16'h0001;
    expect_pulse(4'h1, s + 2*SCAN);
    tick_n(3*SCAN);
    keys = '0;
    tick_n(4*SCAN);
    check("multi_code", key_code, 4'h1);

    // Reset during release debounce of "F", then press "F" again.
    align();
    s = cyc;
    keys = 16'h2000;
    expect_pulse(4'hF, s + 2*SCAN);
    tick_n(3*SCAN);
    keys = '0;
    tick_n(SCAN + 4);
    check("reldb_pressed", key_pressed, 1);
    #2 reset = 1'b1;
    #1;
    check("reldb_reset_pressed", key_pressed, 0);
    check("reldb_reset_code", key_code, 0);
    @(negedge clock);
    reset = 1'b0;
    align();
    s = cyc;
    keys = 16'h2000;
    expect_pulse(4'hF, s + 2*SCAN);
    tick_n(3*SCAN);
    keys = '0;
    tick_n(4*SCAN);
    check("f_again_code", key_code, 4'hF);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the seven-segment display path: scans a 4x4 matrix keypad (Pmod KYPD on the Nexys A7) by strobing one column at a time. The scan rate matches the display's 2 ms digit refresh. Each scan reads the row lines, debounces the result, and reports every accepted key press as a 4-bit hex code with a one-cycle valid pulse. In the top level it sits beside the display driver; `key_code`/`key_valid` feed the value register shown on the 8 digits.

## Interface
- `SCAN_TICKS`, default 200_000: clock cycles per column dwell (2 ms at 100 MHz); benches override it to 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to accept a press or a release; must be ≥1.
- `clock` in 1: 100 MHz system clock. One clock domain only.
- `reset` in 1: asynchronous, active-high; clears all state.
- `row` in 4: keypad rows, active-low (pulled up; a pressed key in the driven column pulls its row low). Asynchronous.
- `col` out 4: column strobes, active-low, exactly one bit low at all times.
- `key_valid` out 1: one-cycle pulse when a press is accepted.
- `key_code` out 4: code of the last accepted key; holds until the next accepted press.
- `key_pressed` out 1: high while the accepted key is considered held.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- Column counter `c` (0..3) drives `col = ~(4'b0001 << c)`.
- Dwell counter counts 0..SCAN_TICKS-1. On its last cycle:
  - store the synchronized `~row` into snapshot bits [4c+3:4c];
  - then advance `c`, wrapping 3→0.
- A full scan is complete when column 3 is sampled. The 16-bit snapshot is then classified:
  - NONE: zero bits set;
  - ONE(k): exactly one bit set, at (row r, column c) → key code k;
  - MULTI: two or more bits set.
- Key map, row r = 0..3 and column c = 0..3 left to right:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Debounce FSM, evaluated once per completed scan:
  - IDLE:
    - ONE(k): latch candidate k, count=1, go to PRESS_DB. If DEBOUNCE_SCANS=1, go straight to HELD instead.
    - NONE or MULTI: stay in IDLE.
  - PRESS_DB:
    - ONE(candidate): count+1. When count reaches DEBOUNCE_SCANS, go to HELD, load `key_code`=candidate, pulse `key_valid`.
    - ONE(other): restart with the new candidate, count=1.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - NONE: count=1, go to REL_DB.
    - Any ONE or MULTI (including a different key): stay in HELD. No auto-repeat and no rollover.
  - REL_DB:
    - NONE: count+1. When count reaches DEBOUNCE_SCANS, go to IDLE.
    - Anything else: return to HELD. No new `key_valid`.
- `key_pressed` = (state is HELD or REL_DB).
- Reset values:
  - state IDLE, c=0, `col`=4'b1110, dwell=0;
  - snapshot=0, counts=0;
  - `key_valid`=0, `key_code`=0, `key_pressed`=0;
  - synchronizer flops = 4'b1111 (idle rows).
- Reset mid-scan or mid-debounce abandons all progress. The first scan after reset starts at column 0.

## Timing
- Full scan = 4·SCAN_TICKS cycles.
- All outputs are registered.
- Row sampling: the sample taken in column c's last dwell cycle reflects `row` as it stood 2 cycles earlier (synchronizer). Settling time is therefore SCAN_TICKS-2 cycles.
- Press latency: `key_valid` asserts 1 cycle after the scan-completion cycle of the DEBOUNCE_SCANS-th matching scan.
- `key_code` updates in the same cycle `key_valid` rises.
- `key_pressed` rises with `key_valid`. It falls 1 cycle after the DEBOUNCE_SCANS-th empty scan completes.
- `key_valid` is never high two cycles in a row. Successive pulses are at least (DEBOUNCE_SCANS+1) scans apart, because a release must be accepted before the next press.

## Structure
- Package `keypad_pkg`:
  - `NUM_ROWS`/`NUM_COLS` = 4;
  - the 16-entry `KEY_MAP` constant, indexed {r,c};
  - `kp_state_t` enum {IDLE, PRESS_DB, HELD, REL_DB};
  - `scan_class_t` enum {NONE, ONE, MULTI}.
- Sub-module `scan_tick_gen`: parameterized modulo-N counter emitting a one-cycle tick every SCAN_TICKS cycles; structurally the same as the display's 2 ms timer. The column counter and debounce FSM stay in `keypad_scanner`.

## Test plan
All scenarios use SCAN_TICKS=4 and DEBOUNCE_SCANS=2 (scan = 16 cycles). The keypad model pulls `row[r]` low only while `col[c]` is low for the pressed (r,c).
- Reset: assert reset asynchronously mid-dwell → `col`=4'b1110, `key_valid`=0, `key_code`=0, `key_pressed`=0 immediately. `col` walks 1110→1101→1011→0111→1110, 4 cycles each, after release.
- Press key at r1,c2 ("6") for 5 scans, then release → exactly one `key_valid` pulse with `key_code`=4'h6, 1 cycle after the 2nd complete scan. `key_pressed` falls after 2 empty scans.
- Bounce: "9" present for 1 scan, absent for 1 scan, repeated 4 times → no `key_valid`; `key_code` keeps its previous value.
- Hold "A" and add "3" while held → single `key_valid` (code 4'hA). No second pulse while both are down or after "A" alone releases, until a full release is accepted.
- Press "1" and "D" simultaneously from IDLE → MULTI, no `key_valid`. Releasing "D" leaves ONE("1") → pulse with `key_code`=4'h1 after 2 scans.
- Assert reset during REL_DB of key "F" → `key_pressed`=0 at once. Pressing "F" again yields a fresh `key_valid` with code 4'hF.
